// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - vectored, masked, fixed-priority interrupt controller
//
// Latches up to NUM_IRQ interrupt lines (edge or level per channel), applies a
// per-channel mask and lowest-index-wins priority, raises one request to the
// control unit, sequences the two-cycle PC push and supplies the handler
// vector. Further requests are blocked until RTI retires.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_irq_in       raw interrupt lines, synchronous to i_clk
//   i_mask_we      mask register write strobe
//   i_mask_wdata   new mask, bit=1 disables the channel
//   i_int_ack      control unit accepted the request at a fetch boundary
//   i_rti_done     one-cycle pulse when RTI leaves the memory stage
//   o_int_req      request to the control unit
//   o_push_step    11 = push PC low half, 01 = push PC high half, 00 = idle
//   o_vector_out   handler address of the selected channel
//   o_active_id    selected channel
//   o_in_service   handler running, nesting blocked
//   o_pending      current pending bits, before masking
module irq_controller #(
    parameter int                 NUM_IRQ       = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK     = {NUM_IRQ{1'b1}},
    parameter logic [31:0]        VECTOR_BASE   = 32'h0000_0000,
    parameter logic [31:0]        VECTOR_STRIDE = 32'h0000_0002,
    localparam int                ID_W          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_IRQ-1:0] i_irq_in,
    input  logic               i_mask_we,
    input  logic [NUM_IRQ-1:0] i_mask_wdata,
    input  logic               i_int_ack,
    input  logic               i_rti_done,
    output logic               o_int_req,
    output logic [1:0]         o_push_step,
    output logic [31:0]        o_vector_out,
    output logic [ID_W-1:0]    o_active_id,
    output logic               o_in_service,
    output logic [NUM_IRQ-1:0] o_pending
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_PUSH_LO,
        S_PUSH_HI,
        S_SERVICE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [NUM_IRQ-1:0] r_prev_irq;
    logic [NUM_IRQ-1:0] r_pend_edge;
    logic [NUM_IRQ-1:0] r_mask;
    logic [ID_W-1:0]    r_active_id;
    logic [31:0]        r_vector;

    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_eligible;
    logic               w_any;
    logic [ID_W-1:0]    w_winner;
    logic [31:0]        w_vec;
    logic               w_accept;

    // Level channels follow the line directly; gating with reset keeps the
    // pending output at zero while reset is held.
    assign w_pending  = (r_pend_edge & EDGE_MASK) | (i_irq_in & ~EDGE_MASK & {NUM_IRQ{i_rst_n}});
    assign w_eligible = w_pending & ~r_mask;
    assign w_any      = |w_eligible;
    assign w_set      = i_irq_in & ~r_prev_irq & EDGE_MASK;
    assign w_accept   = (r_state == S_REQ) && i_int_ack;

    // Lowest index wins: scan downwards so the last hit is the smallest index.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = ID_W'(i);
            end
        end
    end

    // Only the accepted channel's latched edge is consumed.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_clr[i] = w_accept && (r_active_id == ID_W'(i));
        end
    end

    // 32-bit unsigned arithmetic; overflow wraps.
    assign w_vec = VECTOR_BASE + (32'(w_winner) * VECTOR_STRIDE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_int_req    = 1'b0;
        o_push_step  = 2'b00;
        o_in_service = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                o_int_req = 1'b1;
                if (i_int_ack) begin
                    w_state_next = S_PUSH_LO;
                end
            end
            S_PUSH_LO: begin
                o_push_step  = 2'b11;
                w_state_next = S_PUSH_HI;
            end
            S_PUSH_HI: begin
                o_push_step  = 2'b01;
                w_state_next = S_SERVICE;
            end
            S_SERVICE: begin
                o_in_service = 1'b1;
                if (i_rti_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // A new edge in the acceptance cycle re-sets the bit (set wins over clear).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_irq  <= '0;
            r_pend_edge <= '0;
            r_mask      <= '0;
            r_active_id <= '0;
            r_vector    <= VECTOR_BASE;
        end else begin
            r_prev_irq  <= i_irq_in;
            r_pend_edge <= ((r_pend_edge & ~w_clr) | w_set) & EDGE_MASK;
            if (i_mask_we) begin
                r_mask <= i_mask_wdata;
            end
            // The winner is frozen on leaving IDLE; later arrivals never preempt.
            if ((r_state == S_IDLE) && w_any) begin
                r_active_id <= w_winner;
                r_vector    <= w_vec;
            end
        end
    end

    assign o_active_id  = r_active_id;
    assign o_vector_out = r_vector;
    assign o_pending    = w_pending;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - self-checking bench for irq_controller
module tb_irq_controller;

    localparam int         N    = 4;
    localparam logic [3:0] EM   = 4'b1110;
    localparam int         BASE = 0;
    localparam int         STR  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] irq = '0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_wdata = '0;
    logic       ack = 1'b0;
    logic       rti = 1'b0;
    logic       int_req;
    logic [1:0] push_step;
    logic [31:0] vector_out;
    logic [1:0] active_id;
    logic       in_service;
    logic [3:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 idle, 1 requesting, 2 push low, 3 push high, 4 handler
    int         m_phase;
    bit [3:0]   m_latched;
    bit [3:0]   m_prev;
    bit [3:0]   m_mask;
    int         m_id;

    irq_controller #(
        .NUM_IRQ      (N),
        .EDGE_MASK    (EM),
        .VECTOR_BASE  (32'(BASE)),
        .VECTOR_STRIDE(32'(STR))
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_irq_in     (irq),
        .i_mask_we    (mask_we),
        .i_mask_wdata (mask_wdata),
        .i_int_ack    (ack),
        .i_rti_done   (rti),
        .o_int_req    (int_req),
        .o_push_step  (push_step),
        .o_vector_out (vector_out),
        .o_active_id  (active_id),
        .o_in_service (in_service),
        .o_pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit [3:0] model_pending();
        return (m_latched & EM) | (irq & ~EM);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_latched = '0; m_prev = '0; m_mask = '0; m_id = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        bit [3:0] avail;
        bit [3:0] rising;
        avail  = model_pending() & ~m_mask;
        rising = irq & ~m_prev & EM;
        case (m_phase)
            0: if (avail != 0) begin
                   for (int i = 3; i >= 0; i--) if (avail[i]) m_id = i;
                   m_phase = 1;
               end
            1: if (ack) begin
                   m_latched[m_id] = 1'b0;
                   m_phase = 2;
               end
            2: m_phase = 3;
            3: m_phase = 4;
            default: if (rti) m_phase = 0;
        endcase
        m_latched = m_latched | rising;
        m_prev    = irq;
        if (mask_we) m_mask = mask_wdata;
    endtask

    task automatic compare_all();
        check("int_req",    32'(int_req),    32'(m_phase == 1));
        check("push_step",  32'(push_step),  (m_phase == 2) ? 32'd3 : (m_phase == 3) ? 32'd1 : 32'd0);
        check("in_service", 32'(in_service), 32'(m_phase == 4));
        check("active_id",  32'(active_id),  32'(m_id));
        check("vector_out", vector_out,      32'(BASE + m_id * STR));
        check("pending",    32'(pending),    32'(model_pending()));
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        model_reset();
        #2;
        check("rst_int_req",  32'(int_req),   32'd0);
        check("rst_push",     32'(push_step), 32'd0);
        check("rst_vector",   vector_out,     32'(BASE));
        check("rst_pending",  32'(pending),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();

        // Edge on channel 2: pending next edge, request the one after.
        irq[2] = 1'b1;
        step();
        check("ch2_pend", 32'(pending[2]), 32'd1);
        check("ch2_noreq", 32'(int_req), 32'd0);
        step();
        check("ch2_req", 32'(int_req), 32'd1);
        check("ch2_id",  32'(active_id), 32'd2);
        check("ch2_vec", vector_out, 32'h4);
        ack = 1'b1; step(); ack = 1'b0;
        check("ch2_lo", 32'(push_step), 32'd3);
        irq[2] = 1'b0;
        step();
        check("ch2_hi", 32'(push_step), 32'd1);
        step();
        check("ch2_svc", 32'(in_service), 32'd1);
        rti = 1'b1; step(); rti = 1'b0;
        check("ch2_idle", 32'(in_service), 32'd0);

        // Masked channel stays pending without request; unmask requests two cycles later.
        mask_we = 1'b1; mask_wdata = 4'b0010; step(); mask_we = 1'b0;
        irq[1] = 1'b1; step(); step();
        check("mask_noreq", 32'(int_req), 32'd0);
        check("mask_pend",  32'(pending[1]), 32'd1);
        irq[1] = 1'b0;
        mask_we = 1'b1; mask_wdata = 4'b0000; step(); mask_we = 1'b0;
        check("unmask_wait", 32'(int_req), 32'd0);
        step();
        check("unmask_req", 32'(int_req), 32'd1);
        ack = 1'b1; step(); ack = 1'b0;
        step(); step();
        rti = 1'b1; step(); rti = 1'b0;

        // Simultaneous edges on 1 and 3: channel 1 first, then 3.
        irq = 4'b1010; step(); step();
        check("sim_id1",  32'(active_id), 32'd1);
        check("sim_vec1", vector_out, 32'h2);
        irq = 4'b0000;
        ack = 1'b1; step(); ack = 1'b0;
        step(); step();
        rti = 1'b1; step(); rti = 1'b0;
        check("sim_idle", 32'(int_req), 32'd0);
        step();
        check("sim_req3", 32'(int_req), 32'd1);
        check("sim_id3",  32'(active_id), 32'd3);
        check("sim_vec3", vector_out, 32'h6);

        // Reset during PUSH_HI with channel 2 held high across release.
        irq[2] = 1'b1;
        ack = 1'b1; step(); ack = 1'b0;
        step();
        check("pre_rst_hi", 32'(push_step), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_push",    32'(push_step), 32'd0);
        check("mid_rst_req",     32'(int_req),   32'd0);
        check("mid_rst_pending", 32'(pending),   32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rel_noreq", 32'(int_req), 32'd0);
        step();
        check("rel_req", 32'(int_req), 32'd1);
        check("rel_id",  32'(active_id), 32'd2);

        // Randomised traffic against the model, including level channel 0.
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            end
            ack        = ($urandom_range(0, 2) == 0);
            rti        = ($urandom_range(0, 4) == 0);
            mask_we    = ($urandom_range(0, 31) == 0);
            mask_wdata = 4'($urandom_range(0, 15));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Parametrised, vectored interrupt controller that replaces the processor's single `interruptSignal` input. It latches up to NUM_IRQ interrupt lines, applies a per-channel mask and fixed priority, and raises one request to the control unit. It then sequences the two-cycle PC push handshake (same 11/01/00 encoding as the existing INT path) and supplies the handler vector to the PC logic. It blocks further requests until RTI retires.

## Interface
- NUM_IRQ, 4, number of interrupt channels (1..16)
- EDGE_MASK, {NUM_IRQ{1'b1}}, per-channel mode: 1 = rising-edge latched, 0 = level
- VECTOR_BASE, 32'h0000_0000, vector of channel 0
- VECTOR_STRIDE, 32'h0000_0002, vector spacing between channels
- ID_W, max(1, clog2(NUM_IRQ)), derived, not overridden
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- irq_in  in  NUM_IRQ  raw interrupt lines, synchronous to clk
- mask_we  in  1  write strobe for mask register
- mask_wdata  in  NUM_IRQ  new mask; bit=1 disables channel
- int_ack  in  1  control unit accepted the request at a fetch boundary
- rti_done  in  1  one-cycle pulse when RTI leaves memory stage
- int_req  out  1  request to control unit
- push_step  out  2  11 = push PC low half, 01 = push PC high half, 00 = idle
- vector_out  out  32  handler address for the selected channel
- active_id  out  ID_W  selected channel
- in_service  out  1  handler running, nesting blocked
- pending  out  NUM_IRQ  current pending bits, before masking

## Operation
- Edge channels: prev_irq register per channel; rising edge (irq_in=1, prev=0) sets pending bit; bit clears only on acceptance.
- Level channels: pending bit = irq_in, not latched.
- Eligible = pending & ~mask. Priority: lowest index wins.
- FSM states: IDLE, REQ, PUSH_LO, PUSH_HI, SERVICE.
- IDLE: if any eligible, go to REQ; capture winner into active_id.
- REQ: int_req=1, held until int_ack. On int_ack go to PUSH_LO and clear the edge pending bit of active_id. active_id is frozen in REQ; a higher-priority arrival does not preempt.
- PUSH_LO: push_step=11, then PUSH_HI.
- PUSH_HI: push_step=01, then SERVICE.
- SERVICE: in_service=1; wait for rti_done, then IDLE.
- vector_out = VECTOR_BASE + active_id*VECTOR_STRIDE, 32-bit unsigned, wrap on overflow; registered, valid from REQ entry through SERVICE.
- Mask write takes effect the next cycle. Masking in REQ or later does not cancel an accepted or pending request.

## Timing
- Reset values: state IDLE, int_req 0, push_step 00, in_service 0, active_id 0, vector_out VECTOR_BASE, pending 0, mask 0 (all enabled), prev_irq 0.
- An edge channel held high when reset releases counts as an edge on the first clock.
- Latency: edge on cycle N sets pending at N+1 edge; state REQ and int_req=1 at N+2.
- int_ack on cycle A gives push_step 11 at A+1, 01 at A+2, and in_service=1 at A+3.
- int_ack outside REQ is ignored. rti_done outside SERVICE is ignored.
- New edge on the active channel in the same cycle as int_ack: set wins, pending stays 1.
- Edges arriving during PUSH or SERVICE are latched and serviced after return to IDLE; one cycle minimum in IDLE.
- Reset asserted mid-sequence: all outputs take reset values immediately (asynchronously). A partially pushed PC is abandoned.

## Test plan
- NUM_IRQ=4, edge on irq_in[2] at cycle 5, int_ack at cycle 9 -> int_req=1 from cycle 7; push_step 11 @10, 01 @11; vector_out=0x4; active_id=2; in_service @12; rti_done -> IDLE next cycle.
- Simultaneous edges on irq[1] and irq[3] -> channel 1 served first (vector 0x2); channel 3 requested one cycle after IDLE re-entry following rti_done (vector 0x6).
- mask_wdata=4'b0010, edge on irq[1] -> no int_req, pending[1]=1; unmask -> int_req two cycles later.
- Level channel (EDGE_MASK bit 0 = 0): irq[0] held high through RTI -> re-requested after return to IDLE; dropped before ack in REQ -> request still completes with id 0.
- Edge on active channel in ack cycle -> pending stays 1 and is re-serviced after RTI.
- reset low during PUSH_HI -> push_step=00, int_req=0, pending=0 immediately; irq_in high at release -> new request two cycles later.
